// File: rtl/unpool_ctrl_pkg.sv
// rtl/unpool_ctrl_pkg.sv - shared types, word layout and sizing helpers for unpool_ctrl
package unpool_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_WAIT_END,
    ST_CLEAR,
    ST_FIN
  } state_t;

  localparam int WORD_W     = 19;
  localparam int POOLED_LSB = 0;
  localparam int POOLED_W   = 16;
  localparam int HIST_LSB   = 16;
  localparam int HIST_W     = 3;

  // Number of bits needed to hold the value itself (16 -> 5).
  function automatic int bits_required(input int value);
    int b;
    b = 1;
    while ((1 << b) <= value) b = b + 1;
    return b;
  endfunction

  function automatic int size_sq(input int size);
    return size * size;
  endfunction

  function automatic int out_sq(input int size);
    return 4 * size * size;
  endfunction

endpackage

// File: rtl/unpool_addr_gen.sv
// rtl/unpool_addr_gen.sv - channel/k/m counters and buffer address generation
module unpool_addr_gen
  import unpool_ctrl_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int CH_W   = 5,
  parameter int IN_AW  = 12,
  parameter int OUT_AW = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cnt_clr,
  input  logic              k_inc,
  input  logic              m_inc,
  input  logic              ch_inc,
  output logic [CH_W-1:0]   ch,
  output logic              k_last,
  output logic              m_last,
  output logic [IN_AW-1:0]  in_rd_addr,
  output logic [OUT_AW-1:0] out_wr_addr
);

  localparam int SIZE_SQ = size_sq(SIZE);
  localparam int OUT_SQ  = out_sq(SIZE);
  localparam int K_W     = bits_required(SIZE_SQ - 1);
  localparam int M_W     = bits_required(OUT_SQ - 1);
  localparam int IN_PW   = CH_W + bits_required(SIZE_SQ);
  localparam int OUT_PW  = CH_W + bits_required(OUT_SQ);

  logic [K_W-1:0]    k;
  logic [M_W-1:0]    m;
  logic [IN_PW-1:0]  in_full;
  logic [OUT_PW-1:0] out_full;

  assign k_last = (k == K_W'(SIZE_SQ - 1));
  assign m_last = (m == M_W'(OUT_SQ - 1));

  // k and m wrap to zero after their last value so each channel starts clean.
  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr) begin
      ch <= '0;
      k  <= '0;
      m  <= '0;
    end else begin
      if (ch_inc) ch <= ch + CH_W'(1);
      if (k_inc)  k  <= k_last ? '0 : k + K_W'(1);
      if (m_inc)  m  <= m_last ? '0 : m + M_W'(1);
    end
  end

  assign in_full     = IN_PW'(ch) * IN_PW'(SIZE_SQ) + IN_PW'(k);
  assign out_full    = OUT_PW'(ch) * OUT_PW'(OUT_SQ) + OUT_PW'(m);
  assign in_rd_addr  = IN_AW'(in_full);
  assign out_wr_addr = OUT_AW'(out_full);

endmodule

// File: rtl/unpool_ctrl.sv
// rtl/unpool_ctrl.sv - per-channel load/run/drain/clear sequencer for the max-unpooling unit
module unpool_ctrl
  import unpool_ctrl_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int MAX_CH = 16,
  parameter int IN_AW  = 12,
  parameter int OUT_AW = 14,
  localparam int CH_W  = bits_required(MAX_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CH_W-1:0]   n_ch,
  output logic              busy,
  output logic              done,
  output logic              hist_err,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_rd_addr,
  input  logic [18:0]       in_rd_data,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_wr_addr,
  output logic [15:0]       out_wr_data,
  output logic              unp_start,
  output logic              unp_reset_n,
  output logic [15:0]       unp_pooled,
  output logic [2:0]        unp_history,
  input  logic [15:0]       unp_value,
  input  logic              unp_end,
  input  logic              unp_out_end
);

  state_t          state_q, state_d;
  logic [CH_W-1:0] n_ch_q, n_ch_sat, ch;
  logic            start_ok, ch_last, k_last, m_last;
  logic            cnt_clr, k_inc, m_inc, ch_inc;
  logic            clr_q, rd_vld_q;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign n_ch_sat = (n_ch > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : n_ch;
  assign ch_last  = (ch == n_ch_q - CH_W'(1));

  unpool_addr_gen #(
    .SIZE   (SIZE),
    .CH_W   (CH_W),
    .IN_AW  (IN_AW),
    .OUT_AW (OUT_AW)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .cnt_clr     (cnt_clr),
    .k_inc       (k_inc),
    .m_inc       (m_inc),
    .ch_inc      (ch_inc),
    .ch          (ch),
    .k_last      (k_last),
    .m_last      (m_last),
    .in_rd_addr  (in_rd_addr),
    .out_wr_addr (out_wr_addr)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    k_inc   = 1'b0;
    m_inc   = 1'b0;
    ch_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = (n_ch == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        k_inc = 1'b1;
        if (k_last) state_d = ST_RUN;
      end
      ST_RUN:      if (unp_end) state_d = ST_DRAIN;
      ST_DRAIN: begin
        m_inc = 1'b1;
        if (m_last) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: if (unp_out_end) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (ch_last) begin
          state_d = ST_FIN;
        end else begin
          ch_inc  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // clr_q is high exactly for the CLEAR cycle; rd_vld_q marks words returned by the buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      n_ch_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hist_err <= 1'b0;
      clr_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= (state_d == ST_CLEAR);
      rd_vld_q <= in_rd_en;
      done     <= (state_q == ST_FIN);
      if (start_ok) begin
        busy     <= 1'b1;
        n_ch_q   <= n_ch_sat;
        hist_err <= 1'b0;
      end else begin
        if (state_q == ST_FIN) busy <= 1'b0;
        if (rd_vld_q && in_rd_data[HIST_LSB + HIST_W - 1]) hist_err <= 1'b1;
      end
    end
  end

  assign in_rd_en    = (state_q == ST_LOAD);
  assign out_wr_en   = (state_q == ST_DRAIN);
  assign out_wr_data = unp_value;
  assign unp_start   = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                       (state_q == ST_DRAIN) || (state_q == ST_WAIT_END);
  assign unp_reset_n = reset_n & ~clr_q;
  assign unp_pooled  = in_rd_data[POOLED_LSB +: POOLED_W];
  assign unp_history = in_rd_data[HIST_LSB +: HIST_W];

endmodule

// File: tb/tb_unpool_ctrl.sv
// tb/tb_unpool_ctrl.sv - scoreboard bench for unpool_ctrl with SIZE=2 and SIZE=8 instances
module tb_unpool_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [1:0]       start, busy, done, hist_err, in_rd_en, out_wr_en;
  logic [1:0]       unp_start, unp_reset_n, unp_end, unp_out_end;
  logic [1:0][4:0]  n_ch;
  logic [1:0][11:0] in_rd_addr;
  logic [1:0][18:0] in_rd_data;
  logic [1:0][13:0] out_wr_addr;
  logic [1:0][15:0] out_wr_data, unp_pooled, unp_value;
  logic [1:0][2:0]  unp_history;

  unpool_ctrl #(.SIZE(2)) u_dut_s2 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .n_ch(n_ch[0]),
    .busy(busy[0]), .done(done[0]), .hist_err(hist_err[0]),
    .in_rd_en(in_rd_en[0]), .in_rd_addr(in_rd_addr[0]), .in_rd_data(in_rd_data[0]),
    .out_wr_en(out_wr_en[0]), .out_wr_addr(out_wr_addr[0]), .out_wr_data(out_wr_data[0]),
    .unp_start(unp_start[0]), .unp_reset_n(unp_reset_n[0]), .unp_pooled(unp_pooled[0]),
    .unp_history(unp_history[0]), .unp_value(unp_value[0]), .unp_end(unp_end[0]),
    .unp_out_end(unp_out_end[0])
  );

  unpool_ctrl #(.SIZE(8)) u_dut_s8 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .n_ch(n_ch[1]),
    .busy(busy[1]), .done(done[1]), .hist_err(hist_err[1]),
    .in_rd_en(in_rd_en[1]), .in_rd_addr(in_rd_addr[1]), .in_rd_data(in_rd_data[1]),
    .out_wr_en(out_wr_en[1]), .out_wr_addr(out_wr_addr[1]), .out_wr_data(out_wr_data[1]),
    .unp_start(unp_start[1]), .unp_reset_n(unp_reset_n[1]), .unp_pooled(unp_pooled[1]),
    .unp_history(unp_history[1]), .unp_value(unp_value[1]), .unp_end(unp_end[1]),
    .unp_out_end(unp_out_end[1])
  );

  function automatic int side_of(input int g);
    return (g == 0) ? 2 : 8;
  endfunction

  function automatic int s2_of(input int g);
    return side_of(g) * side_of(g);
  endfunction

  // history selects the cell in the 2x2 block: bit1 = row offset, bit0 = column offset
  function automatic int pos_of(input int g, input int k, input logic [2:0] h);
    int s;
    s = side_of(g);
    return (2 * (k / s) + int'(h[1])) * 2 * s + 2 * (k % s) + int'(h[0]);
  endfunction

  logic [18:0] in_mem [2][1024];
  logic [15:0] img [2][256];
  int          u [2];
  logic [1:0]  started;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (in_rd_en[g]) in_rd_data[g] <= in_mem[g][in_rd_addr[g][9:0]];
    end
  end

  // Behavioural unpool unit: init at first unp_start cycle, storage cleared only by unp_reset_n.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!unp_reset_n[g]) begin
        started[g]   <= 1'b0;
        u[g]         <= 0;
        unp_value[g] <= 16'h0;
        for (int i = 0; i < 256; i++) img[g][i] <= 16'h0;
      end else if (unp_start[g]) begin
        started[g] <= 1'b1;
        u[g]       <= started[g] ? u[g] + 1 : 1;
        if (started[g] && u[g] >= 1 && u[g] <= s2_of(g))
          img[g][pos_of(g, u[g] - 1, unp_history[g])] <= unp_pooled[g];
        if (started[g] && u[g] >= 2 * s2_of(g) + 1 && u[g] <= 6 * s2_of(g))
          unp_value[g] <= img[g][u[g] - 2 * s2_of(g) - 1];
      end
    end
  end

  always_comb begin
    unp_end     = '0;
    unp_out_end = '0;
    for (int g = 0; g < 2; g++) begin
      unp_end[g]     = started[g] && (u[g] >= 2 * s2_of(g) + 1);
      unp_out_end[g] = started[g] && (u[g] >= 6 * s2_of(g) + 2);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [29:0] q0[$], q1[$];
  int n_wr[2], n_rd[2], n_us[2], n_clr[2], n_done[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  initial begin
    logic [29:0] e;
    for (int g = 0; g < 2; g++) begin
      n_wr[g] = 0; n_rd[g] = 0; n_us[g] = 0; n_clr[g] = 0; n_done[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (out_wr_en[g]) begin
          n_wr[g]++;
          if ((g == 0 ? q0.size() : q1.size()) == 0) begin
            n_checks++;
            $display("FAIL wr_unexpected: inst %0d actual addr %0d data 0x%0h required no write",
                     g, out_wr_addr[g], out_wr_data[g]);
          end else begin
            if (g == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk(g == 0 ? "wr_s2" : "wr_s8", 32'({out_wr_addr[g], out_wr_data[g]}), 32'(e));
          end
        end
        if (in_rd_en[g])  n_rd[g]++;
        if (unp_start[g]) n_us[g]++;
        if (reset_n && !unp_reset_n[g]) n_clr[g]++;
        if (done[g]) n_done[g]++;
      end
    end
  end

  task automatic load_t1(input logic [2:0] h1);
    in_mem[0][0] = {3'd0, 16'd5};
    in_mem[0][1] = {h1,   16'd6};
    in_mem[0][2] = {3'd2, 16'd7};
    in_mem[0][3] = {3'd3, 16'd8};
  endtask

  task automatic push_t1();
    logic [15:0] d;
    for (int m = 0; m < 16; m++) begin
      d = (m == 0) ? 16'd5 : (m == 3) ? 16'd6 : (m == 12) ? 16'd7 : (m == 15) ? 16'd8 : 16'd0;
      q0.push_back({14'(m), d});
    end
  endtask

  task automatic push_model(input int g, input int n);
    logic [15:0] img_e [256];
    logic [18:0] w;
    int s2;
    s2 = s2_of(g);
    for (int ch = 0; ch < n; ch++) begin
      for (int i = 0; i < 4 * s2; i++) img_e[i] = 16'h0;
      for (int k = 0; k < s2; k++) begin
        w = in_mem[g][ch * s2 + k];
        img_e[pos_of(g, k, w[18:16])] = w[15:0];
      end
      for (int m = 0; m < 4 * s2; m++) begin
        if (g == 0) q0.push_back({14'(ch * 4 * s2 + m), img_e[m]});
        else        q1.push_back({14'(ch * 4 * s2 + m), img_e[m]});
      end
    end
  endtask

  task automatic run_job(input int g, input int n, input int ign_at, input int exp_lat,
                         output logic h1);
    int cyc, d0;
    d0 = n_done[g];
    h1 = 1'b0;
    @(negedge clk);
    n_ch[g]  = 5'(n);
    start[g] = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start[g] = (cyc == ign_at);
      if (cyc == 1) begin
        h1 = hist_err[g];
        chk("busy_on_start", 32'(busy[g]), 32'd1);
      end
      if (done[g] || cyc >= 3000) break;
    end
    chk("done_latency", cyc, exp_lat);
    @(negedge clk);
    chk("done_pulse_count", n_done[g] - d0, 1);
    chk("busy_after_done", 32'(busy[g]), 32'd0);
  endtask

  initial begin
    int w0, r0, s0, c0, t;
    logic h1;
    reset_n = 1'b0;
    start   = '0;
    n_ch    = '0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 1024; i++) in_mem[g][i] = 19'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hist_err", 32'(hist_err), 32'd0);
    chk("rst_in_rd_en", 32'(in_rd_en), 32'd0);
    chk("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_unp_start", 32'(unp_start), 32'd0);
    chk("rst_unp_reset_n", 32'(unp_reset_n), 32'd0);
    chk("rst_in_rd_addr", 32'(in_rd_addr[0]), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("unp_reset_n_released", 32'(unp_reset_n), 32'd3);

    // single channel, hand-computed image
    load_t1(3'd1);
    push_t1();
    w0 = n_wr[0];
    run_job(0, 1, 0, 30, h1);
    chk("t1_writes", n_wr[0] - w0, 16);
    chk("t1_hist_err", 32'(hist_err[0]), 32'd0);

    // three channels with rotating history: stale storage would show up as wrong data
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 4; k++)
        in_mem[0][c * 4 + k] = {3'((k + c) % 4), 16'(16'h100 * (c + 1) + k + 1)};
    push_model(0, 3);
    w0 = n_wr[0];
    c0 = n_clr[0];
    run_job(0, 3, 0, 86, h1);
    chk("t2_writes", n_wr[0] - w0, 48);
    chk("t2_clear_cycles", n_clr[0] - c0, 3);
    chk("t2_queue_empty", q0.size(), 0);

    // zero channels: done only, no buffer or unit activity
    w0 = n_wr[0]; r0 = n_rd[0]; s0 = n_us[0];
    run_job(0, 0, 0, 2, h1);
    chk("t3_no_writes", n_wr[0] - w0, 0);
    chk("t3_no_reads", n_rd[0] - r0, 0);
    chk("t3_no_unp_start", n_us[0] - s0, 0);

    // reset in DRAIN aborts the job
    load_t1(3'd1);
    push_t1();
    @(negedge clk);
    n_ch[0]  = 5'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    t = 0;
    while (!out_wr_en[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reached_drain", 32'(out_wr_en[0]), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    c0 = n_done[0];
    @(negedge clk);
    chk("t4_rst_busy", 32'(busy[0]), 32'd0);
    chk("t4_rst_out_wr_en", 32'(out_wr_en[0]), 32'd0);
    chk("t4_rst_unp_start", 32'(unp_start[0]), 32'd0);
    chk("t4_rst_unp_reset_n", 32'(unp_reset_n[0]), 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_no_done", n_done[0] - c0, 0);
    push_t1();
    w0 = n_wr[0];
    run_job(0, 1, 0, 30, h1);
    chk("t4_clean_writes", n_wr[0] - w0, 16);

    // history > 3 flags hist_err, data still forwarded; start during busy ignored
    load_t1(3'd5);
    push_t1();
    w0 = n_wr[0];
    run_job(0, 1, 5, 30, h1);
    chk("t5_writes", n_wr[0] - w0, 16);
    chk("t5_hist_err_set", 32'(hist_err[0]), 32'd1);
    repeat (5) @(negedge clk);
    chk("t5_hist_err_sticky", 32'(hist_err[0]), 32'd1);
    load_t1(3'd1);
    push_t1();
    run_job(0, 1, 0, 30, h1);
    chk("t5_hist_err_cleared", 32'(h1), 32'd0);
    chk("t5_hist_err_stays_clear", 32'(hist_err[0]), 32'd0);

    // n_ch above MAX_CH saturates to 16 channels
    for (int i = 0; i < 64; i++) in_mem[0][i] = {3'(i % 4), 16'(i * 3 + 1)};
    push_model(0, 16);
    w0 = n_wr[0];
    run_job(0, 20, 0, 450, h1);
    chk("t6_sat_writes", n_wr[0] - w0, 256);

    // SIZE=8, two channels
    for (int i = 0; i < 128; i++) in_mem[1][i] = {3'((i / 3) % 4), 16'(i + 100)};
    push_model(1, 2);
    w0 = n_wr[1];
    run_job(1, 2, 0, 778, h1);
    chk("t7_writes", n_wr[1] - w0, 512);
    chk("t7_hist_err", 32'(hist_err[1]), 32'd0);

    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
